// File: rtl/solver.sv
// Mandelbrot escape-time engine for a single point held as multi-limb fixed point.
// Operands are normalised to a full-width datapath (MAX_LIMBS limbs, 4 integer bits)
// and the result bits below the active precision are masked off. The masking keeps
// the arithmetic identical to running at the active width N.
module solver #(
  parameter int unsigned LIMB_INDEX_BITS   = 6,
  parameter int unsigned LIMB_SIZE_BITS    = 8,
  parameter int unsigned DIVERGENCE_RADIUS = 4,
  parameter int unsigned MAX_LIMBS         = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_real_en,
  input  logic                       wr_imag_en,
  input  logic [LIMB_INDEX_BITS-1:0] wr_index,
  input  logic [LIMB_SIZE_BITS-1:0]  real_data,
  input  logic [LIMB_SIZE_BITS-1:0]  imag_data,
  input  logic                       wr_num_limbs_en,
  input  logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  input  logic                       wr_iter_lim_en,
  input  logic [15:0]                iter_lim_data,
  input  logic                       start,
  output logic                       out_ready,
  output logic [15:0]                iterations
);

  localparam int unsigned W  = MAX_LIMBS * LIMB_SIZE_BITS; // stored operand width
  localparam int unsigned F  = W - 4;                      // fraction bits
  localparam int unsigned E  = W + 4;                      // extended width, 8 integer bits
  localparam int unsigned P  = 2 * E;                      // product width
  localparam int unsigned IW = (MAX_LIMBS > 1) ? $clog2(MAX_LIMBS) : 1;
  localparam int unsigned CW = 16;

  localparam logic signed [P-1:0] RADIUS_FX = P'(DIVERGENCE_RADIUS) << F;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                      state_q, state_d;
  logic [LIMB_SIZE_BITS-1:0]   re_limb_q [MAX_LIMBS];
  logic [LIMB_SIZE_BITS-1:0]   re_limb_d [MAX_LIMBS];
  logic [LIMB_SIZE_BITS-1:0]   im_limb_q [MAX_LIMBS];
  logic [LIMB_SIZE_BITS-1:0]   im_limb_d [MAX_LIMBS];
  logic [LIMB_INDEX_BITS-1:0]  num_limbs_q, num_limbs_d;
  logic [CW-1:0]               iter_lim_q, iter_lim_d;
  logic signed [W-1:0]         z_re_q, z_re_d;
  logic signed [W-1:0]         z_im_q, z_im_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        out_ready_q, out_ready_d;
  logic [CW-1:0]               iterations_q, iterations_d;

  logic [7:0]                  norm_sh;
  logic [W-1:0]                c_re_raw, c_im_raw;
  logic signed [W-1:0]         c_re_n, c_im_n;
  logic [P-1:0]                frac_mask;
  logic signed [P-1:0]         sq_re, sq_im, cross2, mag;
  logic signed [E-1:0]         re_nx, im_nx;
  logic                        diverge;

  assign out_ready  = out_ready_q;
  assign iterations = iterations_q;

  // One full iteration z' = z^2 + c and its escape test, evaluated in a single cycle
  always_comb begin
    norm_sh  = 8'((MAX_LIMBS - 32'(num_limbs_q)) * LIMB_SIZE_BITS);
    c_re_raw = '0;
    c_im_raw = '0;
    for (int unsigned i = 0; i < MAX_LIMBS; i++) begin
      if (i < 32'(num_limbs_q)) begin
        c_re_raw[i*LIMB_SIZE_BITS +: LIMB_SIZE_BITS] = re_limb_q[i];
        c_im_raw[i*LIMB_SIZE_BITS +: LIMB_SIZE_BITS] = im_limb_q[i];
      end
    end
    c_re_n    = $signed(c_re_raw << norm_sh);
    c_im_n    = $signed(c_im_raw << norm_sh);
    frac_mask = ~((P'(1) << norm_sh) - P'(1));

    sq_re  = ((P'(z_re_q) * P'(z_re_q)) >>> F) & $signed(frac_mask);
    sq_im  = ((P'(z_im_q) * P'(z_im_q)) >>> F) & $signed(frac_mask);
    cross2 = (((P'(z_re_q) * P'(z_im_q)) <<< 1) >>> F) & $signed(frac_mask);

    re_nx = E'(sq_re - sq_im + P'(c_re_n));
    im_nx = E'(cross2 + P'(c_im_n));

    mag = (((P'(re_nx) * P'(re_nx)) >>> F) & $signed(frac_mask))
        + (((P'(im_nx) * P'(im_nx)) >>> F) & $signed(frac_mask));
    diverge = mag > RADIUS_FX;
  end

  // Next-state, register writes and result capture
  always_comb begin
    state_d      = state_q;
    re_limb_d    = re_limb_q;
    im_limb_d    = im_limb_q;
    num_limbs_d  = num_limbs_q;
    iter_lim_d   = iter_lim_q;
    z_re_d       = z_re_q;
    z_im_d       = z_im_q;
    count_d      = count_q;
    out_ready_d  = out_ready_q;
    iterations_d = iterations_q;

    if (state_q != BUSY) begin
      if (wr_real_en && (32'(wr_index) < MAX_LIMBS)) begin
        re_limb_d[wr_index[IW-1:0]] = real_data;
      end
      if (wr_imag_en && (32'(wr_index) < MAX_LIMBS)) begin
        im_limb_d[wr_index[IW-1:0]] = imag_data;
      end
      if (wr_num_limbs_en) begin
        if (num_limbs_data == '0) begin
          num_limbs_d = LIMB_INDEX_BITS'(1);
        end else if (32'(num_limbs_data) > MAX_LIMBS) begin
          num_limbs_d = LIMB_INDEX_BITS'(MAX_LIMBS);
        end else begin
          num_limbs_d = num_limbs_data;
        end
      end
      if (wr_iter_lim_en) begin
        iter_lim_d = iter_lim_data;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = BUSY;
          out_ready_d = 1'b0;
          z_re_d      = '0;
          z_im_d      = '0;
          count_d     = '0;
        end
      end
      BUSY: begin
        if (count_q == iter_lim_q) begin
          state_d      = DONE;
          out_ready_d  = 1'b1;
          iterations_d = count_q;
        end else begin
          count_d = count_q + CW'(1);
          if (diverge) begin
            state_d      = DONE;
            out_ready_d  = 1'b1;
            iterations_d = count_q + CW'(1);
          end else begin
            z_re_d = W'(re_nx);
            z_im_d = W'(im_nx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and storage registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < MAX_LIMBS; i++) begin
        re_limb_q[i] <= '0;
        im_limb_q[i] <= '0;
      end
      num_limbs_q  <= LIMB_INDEX_BITS'(1);
      iter_lim_q   <= '0;
      z_re_q       <= '0;
      z_im_q       <= '0;
      count_q      <= '0;
      out_ready_q  <= 1'b0;
      iterations_q <= '0;
    end else begin
      state_q      <= state_d;
      re_limb_q    <= re_limb_d;
      im_limb_q    <= im_limb_d;
      num_limbs_q  <= num_limbs_d;
      iter_lim_q   <= iter_lim_d;
      z_re_q       <= z_re_d;
      z_im_q       <= z_im_d;
      count_q      <= count_d;
      out_ready_q  <= out_ready_d;
      iterations_q <= iterations_d;
    end
  end

endmodule

// File: tb/tb_solver.sv
// Scoreboard bench for solver: expected counts are queued at start, a monitor
// compares them whenever out_ready rises.
module tb_solver;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_real_en, wr_imag_en;
  logic [5:0]  wr_index;
  logic [7:0]  real_data, imag_data;
  logic        wr_num_limbs_en;
  logic [5:0]  num_limbs_data;
  logic        wr_iter_lim_en;
  logic [15:0] iter_lim_data;
  logic        start;
  logic        out_ready;
  logic [15:0] iterations;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int last_exp = 0;
  int exp_v;
  logic prev_ready = 1'b0;

  solver dut (
    .clock(clock), .reset(reset),
    .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en), .wr_index(wr_index),
    .real_data(real_data), .imag_data(imag_data),
    .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
    .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
    .start(start), .out_ready(out_ready), .iterations(iterations)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Escape-time reference working directly at the active precision N
  function automatic int model(input longint cre, input longint cim, input int n, input int lim);
    int     s   = n * 8 - 4;
    longint zr  = 0;
    longint zi  = 0;
    longint nr, ni;
    int     cnt = 0;
    while (cnt != lim) begin
      nr = ((zr * zr) >>> s) - ((zi * zi) >>> s) + cre;
      ni = ((2 * zr * zi) >>> s) + cim;
      cnt++;
      if (((nr * nr) >>> s) + ((ni * ni) >>> s) > (longint'(4) <<< s)) return cnt;
      zr = nr;
      zi = ni;
    end
    return cnt;
  endfunction

  function automatic longint sx(input longint raw, input int n);
    longint m = longint'(1) << n;
    longint v = raw & (m - 1);
    if (v >= m / 2) v = v - m;
    return v;
  endfunction

  // Monitor: every rising out_ready consumes one expectation
  always @(negedge clock) begin
    if (out_ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d, expected no result", iterations);
      end else begin
        exp_v = exp_q.pop_front();
        check("iterations", longint'(iterations), longint'(exp_v));
      end
    end
    prev_ready = out_ready;
  end

  task automatic load(input int n, input int nlw, input longint cre, input longint cim, input int lim);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      wr_real_en = 1'b1;
      wr_imag_en = 1'b1;
      wr_index   = 6'(i);
      real_data  = (i < n) ? 8'(cre >> (8 * i)) : 8'($urandom);
      imag_data  = (i < n) ? 8'(cim >> (8 * i)) : 8'($urandom);
    end
    @(negedge clock);
    wr_index  = 6'(4 + $urandom_range(0, 59));
    real_data = 8'($urandom);
    imag_data = 8'($urandom);
    @(negedge clock);
    wr_real_en      = 1'b0;
    wr_imag_en      = 1'b0;
    wr_num_limbs_en = 1'b1;
    num_limbs_data  = 6'(nlw);
    wr_iter_lim_en  = 1'b1;
    iter_lim_data   = 16'(lim);
    @(negedge clock);
    wr_num_limbs_en = 1'b0;
    wr_iter_lim_en  = 1'b0;
  endtask

  task automatic start_run(input int exp);
    exp_q.push_back(exp);
    last_exp = exp;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ready_low_after_start", longint'(out_ready), 0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!out_ready && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (!out_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: out_ready still 0 after %0d cycles, expected 1", budget);
      exp_q.delete();
    end
  endtask

  task automatic run(input int exp, input int budget);
    start_run(exp);
    wait_done(budget);
  endtask

  initial begin
    int     n, nlw, lim, e;
    longint half, cre, cim;

    reset = 1'b0;
    wr_real_en = 1'b0; wr_imag_en = 1'b0; wr_index = '0;
    real_data = '0; imag_data = '0;
    wr_num_limbs_en = 1'b0; num_limbs_data = '0;
    wr_iter_lim_en = 1'b0; iter_lim_data = '0;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_out_ready", longint'(out_ready), 0);
    check("reset_iterations", longint'(iterations), 0);
    reset = 1'b1;

    // Defaults after reset: iter_lim 0 gives 0
    run(0, 20);

    // Far-away point escapes on the first step, repeated runs are identical
    for (int r = 0; r < 4; r++) begin
      load(2, 2, sx(64'h0400, 16), sx(64'hBC00, 16), 10);
      run(1, 50);
    end

    load(2, 2, sx(64'h1000, 16), 0, 10);
    run(3, 50);
    repeat (3) @(negedge clock);
    check("hold_ready", longint'(out_ready), 1);
    check("hold_iterations", longint'(iterations), longint'(last_exp));

    // |z|^2 stays exactly at the radius: never escapes
    load(2, 2, sx(64'hE000, 16), 0, 10);
    run(10, 50);

    load(2, 2, 0, 0, 0);
    run(0, 20);
    load(2, 2, sx(64'h0400, 16), 0, 65535);
    run(65535, 70000);

    // start and writes while busy are ignored
    load(2, 2, sx(64'h0400, 16), 0, 300);
    start_run(300);
    repeat (20) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start           = 1'b0;
    wr_real_en      = 1'b1;
    wr_imag_en      = 1'b1;
    wr_index        = 6'd1;
    real_data       = 8'h7F;
    imag_data       = 8'h55;
    wr_num_limbs_en = 1'b1;
    num_limbs_data  = 6'd1;
    wr_iter_lim_en  = 1'b1;
    iter_lim_data   = 16'd5;
    @(negedge clock);
    wr_real_en = 1'b0; wr_imag_en = 1'b0;
    wr_num_limbs_en = 1'b0; wr_iter_lim_en = 1'b0;
    wait_done(400);
    run(300, 400);

    // Reset mid-run aborts at once
    load(4, 4, 0, 0, 1000);
    start_run(1000);
    repeat (30) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrun_reset_ready", longint'(out_ready), 0);
    check("midrun_reset_iterations", longint'(iterations), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    load(4, 4, longint'(1) << 28, 0, 10);
    run(3, 50);

    // Random points with |c_re|,|c_im| < 2, including clamped limb counts
    for (int r = 0; r < 30; r++) begin
      n   = $urandom_range(1, 4);
      nlw = n;
      if (n == 1 && $urandom_range(0, 1) == 1) nlw = 0;
      if (n == 4 && $urandom_range(0, 1) == 1) nlw = $urandom_range(5, 63);
      half = longint'(1) << (8 * n - 3);
      cre  = longint'($urandom_range(0, 32'(2 * half - 1))) - half;
      cim  = longint'($urandom_range(0, 32'(2 * half - 1))) - half;
      lim  = $urandom_range(0, 40);
      e    = model(cre, cim, n, lim);
      load(n, nlw, cre, cim, lim);
      run(e, 100);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/solver.md
Name: solver

Overview:
- Mandelbrot escape-time engine for one point c = c_re + i*c_im held as multi-limb two's-complement fixed point.
- Iterates z <- z^2 + c from z = 0 and reports how many iterations ran before |z|^2 exceeded the divergence radius, or the iteration limit was reached.
- Sits behind a host or register interface that loads limbs and configuration, pulses start, and polls out_ready.

Parameters:
- LIMB_INDEX_BITS, 6: width of limb index and limb-count fields.
- LIMB_SIZE_BITS, 8: bits per limb.
- DIVERGENCE_RADIUS, 4: escape threshold on |z|^2, an integer compared as the fixed-point value DIVERGENCE_RADIUS.0.
- MAX_LIMBS, 4: limb storage depth per operand; sizes the datapath.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr_real_en  in  1  write real_data into c_re limb wr_index.
- wr_imag_en  in  1  write imag_data into c_im limb wr_index.
- wr_index  in  LIMB_INDEX_BITS  limb index; 0 is least significant.
- real_data  in  LIMB_SIZE_BITS  c_re limb value.
- imag_data  in  LIMB_SIZE_BITS  c_im limb value.
- wr_num_limbs_en  in  1  latch num_limbs_data.
- num_limbs_data  in  LIMB_INDEX_BITS  active limb count; legal range 1..MAX_LIMBS.
- wr_iter_lim_en  in  1  latch iter_lim_data.
- iter_lim_data  in  16  maximum iteration count.
- start  in  1  begin computation; single-cycle pulse.
- out_ready  out  1  result valid.
- iterations  out  16  iteration count result.

Behaviour:
- Reset (reset=0, asynchronous): all limbs 0, num_limbs=1, iter_lim=0, out_ready=0, iterations=0, state IDLE. Reset mid-run aborts immediately.
- Number format:
  - N = num_limbs*LIMB_SIZE_BITS bits, two's complement.
  - Limb num_limbs-1 is most significant and carries the sign.
  - 4 integer bits including sign: value = raw/2^(N-4), range [-8, 8).
  - Limbs at index >= num_limbs are ignored.
- Writes:
  - Register writes and config latches take effect on the clock edge.
  - Writes with wr_index >= MAX_LIMBS are ignored.
  - num_limbs_data outside 1..MAX_LIMBS is clamped into range.
  - All writes are ignored while BUSY.
  - Stored values persist across runs.
- States:
  - IDLE --start--> BUSY. On this edge: out_ready<=0, z<=0, count<=0.
  - BUSY --done--> DONE. On this edge: out_ready<=1, iterations<=count.
  - DONE --start--> BUSY.
  - start while BUSY is ignored.
- Iteration step:
  - If count == iter_lim, finish with iterations=count. iter_lim=0 gives 0.
  - Otherwise compute z' = z^2 + c in extended width (N+4 bits, 8 integer bits):
    - re' = re^2 - im^2 + c_re
    - im' = 2*re*im + c_im
  - Products are full precision, then arithmetic-shifted right by N-4 (floor truncation).
  - count <= count+1.
  - If re'^2 + im'^2 > DIVERGENCE_RADIUS (strict, extended width), finish with iterations=count.
  - Otherwise z <= z', truncated to N bits. This is lossless because |z'| <= 2.
- Cycles per iteration are implementation-defined, but constant and at most 8 for num_limbs <= MAX_LIMBS.
- Results are fully deterministic: identical inputs produce identical iterations on every run with no state leakage between runs.
- iterations and out_ready hold stable in DONE until the next accepted start.

Test Plan:
- num_limbs=2, iter_lim=10, c_re limbs {0x00, 0x04} (0.25), c_im limbs {0x00, 0xbc} (-4.25), start -> out_ready rises, iterations=1. Repeat 4 times with reloaded config and limbs -> 1 every run; out_ready drops the cycle after each start.
- num_limbs=2, c_re=0x1000 (1.0), c_im=0, iter_lim=10 -> iterations=3 (|z|^2 = 1, 4, 25).
- c_re=0xE000 (-2.0), c_im=0, iter_lim=10 -> |z|^2 stays exactly 4 (not > 4) -> iterations=10.
- c=0, iter_lim=0 -> iterations=0. Then iter_lim=65535 with c_re=0x0400, c_im=0 -> iterations=65535.
- Assert reset mid-run -> out_ready=0 and iterations=0 immediately. A subsequent full load and start still gives correct results.
- start pulsed while BUSY, and limb writes issued while BUSY -> no effect on the current or next result.
